// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder/subtractor family:
// default width, half-split rule and per-bit generate/propagate helpers.
package cla_pkg;

  localparam int unsigned CLA_WIDTH = 32'd13;

  // Width of the low half resolved in the first pipeline stage.
  function automatic int unsigned lo_width(input int unsigned w);
    return w / 32'd2;
  endfunction

  // Returns {generate, propagate} for one bit position.
  function automatic logic [1:0] gen_prop(input logic a, input logic b);
    return {a & b, a | b};
  endfunction

  // Lookahead carry into the next bit from this bit's G/P and incoming carry.
  function automatic logic next_carry(input logic [1:0] gp, input logic c);
    return gp[1] | (gp[0] & c);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder over W bits: sum = a + b + cin.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned W = 32'd8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   carry_s;
  logic [W-1:0] sum_s;

  // Carry chain from per-bit generate/propagate, then per-bit sum.
  always_comb begin
    carry_s    = '0;
    sum_s      = '0;
    carry_s[0] = cin;
    for (int i = 0; i < int'(W); i++) begin
      carry_s[i+1] = next_carry(gen_prop(a[i], b[i]), carry_s[i]);
      sum_s[i]     = a[i] ^ b[i] ^ carry_s[i];
    end
  end

  assign sum  = sum_s;
  assign cout = carry_s[W];

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined subtractor (A + ~B + 1) on carry-lookahead halves,
// with valid/ready handshake on input and output.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned LO_W  = lo_width(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int unsigned HI_W = WIDTH - LO_W;

  logic [WIDTH-1:0] bsub_s;
  logic [LO_W-1:0]  lo_sum_s;
  logic             lo_cout_s;
  logic [HI_W-1:0]  hi_sum_s;
  logic             hi_cout_s;
  logic             adv1_s;
  logic             adv2_s;
  logic             in_xfer_s;

  logic             s1_valid_r;
  logic [LO_W-1:0]  s1_lo_sum_r;
  logic             s1_c_lo_r;
  logic [HI_W-1:0]  s1_min_hi_r;
  logic [HI_W-1:0]  s1_bsub_hi_r;
  logic             o_valid_r;
  logic [WIDTH-1:0] o_diff_r;
  logic             o_borrow_r;

  assign bsub_s = ~i_sub;

  cla_slice #(.W(LO_W)) u_lo (
    .a    (i_min[LO_W-1:0]),
    .b    (bsub_s[LO_W-1:0]),
    .cin  (1'b1),
    .sum  (lo_sum_s),
    .cout (lo_cout_s)
  );

  cla_slice #(.W(HI_W)) u_hi (
    .a    (s1_min_hi_r),
    .b    (s1_bsub_hi_r),
    .cin  (s1_c_lo_r),
    .sum  (hi_sum_s),
    .cout (hi_cout_s)
  );

  // Stage 2 moves when the output is empty or being consumed; stage 1 when
  // it is empty or can hand its contents to stage 2.
  assign adv2_s    = ~o_valid_r | i_ready;
  assign adv1_s    = ~s1_valid_r | adv2_s;
  assign in_xfer_s = i_valid & adv1_s;
  assign o_ready   = adv1_s;

  // Stage 1: low half resolved, high operand slices parked for stage 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_lo_sum_r  <= '0;
      s1_c_lo_r    <= 1'b0;
      s1_min_hi_r  <= '0;
      s1_bsub_hi_r <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= i_valid;
      if (in_xfer_s) begin
        s1_lo_sum_r  <= lo_sum_s;
        s1_c_lo_r    <= lo_cout_s;
        s1_min_hi_r  <= i_min[WIDTH-1:LO_W];
        s1_bsub_hi_r <= bsub_s[WIDTH-1:LO_W];
      end
    end
  end

  // Stage 2: high half resolved; borrow is the inverted final carry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_r  <= 1'b0;
      o_diff_r   <= '0;
      o_borrow_r <= 1'b0;
    end else if (adv2_s) begin
      o_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        o_diff_r   <= {hi_sum_s, s1_lo_sum_r};
        o_borrow_r <= ~hi_cout_s;
      end
    end
  end

  assign o_valid  = o_valid_r;
  assign o_diff   = o_diff_r;
  assign o_borrow = o_borrow_r;

endmodule
